adder_share_ctrl: RTL and testbench

Shared-adder controller for the RISC-V core's adder slice. It arbitrates between two requesters (port 0: fetch/PC path, port 1: execute/branch-target path) with round-robin fairness. It sequences one accepted add/subtract over a narrow SLICE-bit adder in WIDTH/SLICE cycles, with the carry held in a register, and returns sum, carry-out and signed overflow on a single tagged response channel with valid/ready backpressure.

---
 rtl/adder_share_ctrl.sv | 132 +++++++++++++
 tb/tb_adder_share_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// Shared narrow-adder controller: round-robin arbitration between two requesters,
// then a WIDTH-bit add/subtract sequenced over SLICE-bit slices with a registered carry.
module adder_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_cout,
    output logic             resp_ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic             last_grant;
    logic             carry;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic             grant1;
    logic             handshake;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] s_slice;
    logic             c_slice;
    logic [WIDTH-1:0] sum_next;
    logic             last_slice;

    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    always_comb begin
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = !rst && (state == IDLE) && req0_valid && !grant1;
        req1_ready = !rst && (state == IDLE) && grant1;
        handshake  = req0_ready || req1_ready;
        resp_valid = (state == DONE);
        last_slice = (k == KW'(N - 1));
    end

    always_comb begin
        a_slice  = '0;
        b_slice  = '0;
        sum_next = resp_sum;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                a_slice = a_reg[i*SLICE +: SLICE];
                b_slice = b_reg[i*SLICE +: SLICE];
            end
        end
        {c_slice, s_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry};
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                sum_next[i*SLICE +: SLICE] = s_slice;
            end
        end
    end

    // b is stored pre-inverted for subtract so the slice adder only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            carry      <= 1'b0;
            k          <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            resp_id    <= 1'b0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            resp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        if (grant1) begin
                            a_reg <= req1_a;
                            b_reg <= req1_sub ? ~req1_b : req1_b;
                            carry <= req1_sub;
                        end else begin
                            a_reg <= req0_a;
                            b_reg <= req0_sub ? ~req0_b : req0_b;
                            carry <= req0_sub;
                        end
                        resp_id    <= grant1;
                        last_grant <= grant1;
                        k          <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    resp_sum <= sum_next;
                    carry    <= c_slice;
                    if (last_slice) begin
                        resp_cout <= c_slice;
                        resp_ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (s_slice[SLICE-1] != a_reg[WIDTH-1]);
                        state     <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Randomized and directed bench for adder_share_ctrl against an arithmetic reference model
// with a round-robin grant model.
module tb_adder_share_ctrl;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_sub;
    logic             req1_valid, req1_ready, req1_sub;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             resp_valid, resp_ready, resp_id, resp_cout, resp_ovf;
    logic [WIDTH-1:0] resp_sum;

    int               checks = 0;
    int               errors = 0;
    logic             last_m;
    logic             obs_id, obs_cout, obs_ovf;
    logic [31:0]      obs_sum;

    always #5 clk = ~clk;

    adder_share_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_ovf(resp_ovf)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Signed overflow is judged by comparing the exact integer result with the truncated one.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                     output logic [31:0] sum, output logic cout, output logic ovf);
        longint     sa, sb, exact;
        logic [32:0] wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            sum   = a - b;
            cout  = (a >= b);
            exact = sa - sb;
        end else begin
            wide  = {1'b0, a} + {1'b0, b};
            sum   = wide[31:0];
            cout  = wide[32];
            exact = sa + sb;
        end
        ovf = (exact != longint'($signed(sum)));
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Entered and left at a falling edge while the controller sits in IDLE.
    task automatic applyStimulus(input logic v0, input logic v1,
                                 input logic [31:0] a0, input logic [31:0] b0, input logic s0,
                                 input logic [31:0] a1, input logic [31:0] b1, input logic s1,
                                 input int hold);
        logic        g1, ec, eo;
        logic [31:0] es;
        int          lat;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
        resp_ready = 1'b0;
        g1 = v1 && (!v0 || !last_m);
        #1;
        checkOutput("req0_ready", req0_ready, v0 && !g1);
        checkOutput("req1_ready", req1_ready, g1);
        if (g1) refModel(a1, b1, s1, es, ec, eo);
        else    refModel(a0, b0, s0, es, ec, eo);
        last_m = g1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            checkOutput("busy_ready", {req0_ready, req1_ready}, 2'b00);
        end while (!resp_valid && lat < 50);
        checkOutput("latency", lat, N + 1);
        checkOutput("resp_id", resp_id, g1);
        checkOutput("resp_sum", resp_sum, es);
        checkOutput("resp_cout", resp_cout, ec);
        checkOutput("resp_ovf", resp_ovf, eo);
        obs_id = resp_id; obs_sum = resp_sum; obs_cout = resp_cout; obs_ovf = resp_ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", resp_valid, 1'b1);
            checkOutput("hold_fields", {resp_id, resp_cout, resp_ovf, resp_sum}, {g1, ec, eo, es});
            checkOutput("hold_ready", {req0_ready, req1_ready}, 2'b00);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("back_to_idle", resp_valid, 1'b0);
    endtask

    logic [31:0] plan_a   [5] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000};
    logic [31:0] plan_b   [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001};
    logic        plan_sub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] plan_sum [5] = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
    logic        plan_cout[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        plan_ovf [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic v0, v1;
        rst = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {req0_ready, req1_ready}, 2'b00);
        checkOutput("rst_valid", resp_valid, 1'b0);
        checkOutput("rst_fields", {resp_id, resp_cout, resp_ovf, resp_sum}, '0);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        last_m = 1'b1;
        @(negedge clk);

        $display("[TB] arbitration with both ports valid");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, $urandom, $urandom, 1'b0, $urandom, $urandom, 1'b1, 0);
            checkOutput("arb_order", obs_id, (i % 2 == 1));
        end

        $display("[TB] lone requester 1 repeated");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, $urandom, $urandom, 1'b0, 0);
            checkOutput("lone_req1", obs_id, 1'b1);
        end

        $display("[TB] directed arithmetic vectors");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, plan_a[i], plan_b[i], plan_sub[i], 32'h0, 32'h0, 1'b0, 0);
            checkOutput("plan_sum", obs_sum, plan_sum[i]);
            checkOutput("plan_flags", {obs_cout, obs_ovf}, {plan_cout[i], plan_ovf[i]});
        end

        $display("[TB] response backpressure");
        applyStimulus(1'b1, 1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h0, 32'h0, 1'b0, 3);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 30; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            applyStimulus(v0, v1, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                          pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)));
        end

        $display("[TB] reset during BUSY");
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_sub = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready", {req0_ready, req1_ready}, 2'b00);
        checkOutput("midrst_valid", resp_valid, 1'b0);
        checkOutput("midrst_fields", {resp_id, resp_cout, resp_ovf, resp_sum}, '0);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        last_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_resp", resp_valid, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 32'd2, 32'd3, 1'b0, 32'd9, 32'd9, 1'b0, 0);
        checkOutput("post_rst_id", obs_id, 1'b0);
        checkOutput("post_rst_sum", obs_sum, 32'd5);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
